// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for an 8-bit accumulator-less ISA driving a 4-entry
// register file, an external ALU and a handshaked memory port.
module instr_sequencer #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_BUS_WIDTH-1:0] mem_addr,
    output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
    input  logic                      mem_ack,
    output logic                      reg_op,
    output logic [1:0]                reg_1_sel,
    output logic [1:0]                reg_2_sel,
    input  logic [DATA_BUS_WIDTH-1:0] reg_1_data,
    input  logic [DATA_BUS_WIDTH-1:0] reg_2_data,
    output logic [DATA_BUS_WIDTH-1:0] reg_wdata,
    output logic [2:0]                alu_op,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  logic                      alu_zero,
    output logic [DATA_BUS_WIDTH-1:0] pc,
    output logic                      halted,
    output logic                      illegal
);
    // state     | meaning
    // FETCH     | read opcode byte at pc      FETCH_IMM | read immediate byte at pc
    // DECODE    | pick imm fetch/exec/halt    EXEC      | one-cycle execute
    // MEM       | LD/ST data access           WB        | write loaded byte to rd
    // HALT      | parked until reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_FETCH_IMM, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [DATA_BUS_WIDTH-1:0] PC_STEP = 1;

    state_t                    state_q, state_d;
    logic [DATA_BUS_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_BUS_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_BUS_WIDTH-1:0] imm_q, imm_d;
    logic [DATA_BUS_WIDTH-1:0] mdr_q, mdr_d;
    logic                      zflag_q, zflag_d;

    logic                      req_c, we_c, reg_op_c, halted_c, illegal_c;
    logic [DATA_BUS_WIDTH-1:0] addr_c, wdata_c, reg_wdata_c;
    logic [2:0]                alu_op_c;
    logic [3:0]                opcode;

    assign opcode    = ir_q[7:4];
    assign reg_1_sel = ir_q[3:2];
    assign reg_2_sel = ir_q[1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            mdr_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            mdr_q   <= mdr_d;
            zflag_q <= zflag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        mdr_d       = mdr_q;
        zflag_d     = zflag_q;
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_c      = pc_q;
        wdata_c     = '0;
        reg_op_c    = 1'b0;
        reg_wdata_c = '0;
        alu_op_c    = 3'd0;
        halted_c    = 1'b0;
        illegal_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDI, OP_JMP, OP_JZ: state_d = S_FETCH_IMM;
                    OP_HALT:               state_d = S_HALT;
                    default:               state_d = S_EXEC;
                endcase
            end
            S_FETCH_IMM: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    imm_d   = mem_rdata;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI: begin
                        reg_op_c    = 1'b1;
                        reg_wdata_c = imm_q;
                    end
                    OP_MOV: begin
                        reg_op_c    = 1'b1;
                        reg_wdata_c = reg_2_data;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        // opcodes 3..7 map straight onto ALU codes 0..4
                        reg_op_c    = 1'b1;
                        alu_op_c    = opcode[2:0] - 3'd3;
                        reg_wdata_c = alu_result;
                        zflag_d     = alu_zero;
                    end
                    OP_JMP: pc_d = imm_q;
                    OP_JZ: begin
                        if (zflag_q) pc_d = imm_q;
                    end
                    OP_LD, OP_ST: state_d = S_MEM;
                    4'hC, 4'hD, 4'hE: illegal_c = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = (opcode == OP_ST);
                addr_c  = reg_2_data;
                wdata_c = reg_1_data;
                if (mem_ack) begin
                    if (opcode == OP_ST) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_op_c    = 1'b1;
                reg_wdata_c = mdr_q;
                state_d     = S_FETCH;
            end
            S_HALT:  halted_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks the strobes so a request in flight drops while reset is held.
    assign mem_req   = req_c & reset;
    assign mem_we    = we_c & reset;
    assign reg_op    = reg_op_c & reset;
    assign halted    = halted_c & reset;
    assign illegal   = illegal_c & reset;
    assign mem_addr  = addr_c;
    assign mem_wdata = wdata_c;
    assign reg_wdata = reg_wdata_c;
    assign alu_op    = alu_op_c;
    assign pc        = pc_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: register file, ALU and memory modelled around the DUT,
// directed scenarios followed by random programs checked against an ISA-level model.
module tb_instr_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata = 8'h00;
    logic       reg_op;
    logic [1:0] reg_1_sel, reg_2_sel;
    logic [7:0] reg_1_data, reg_2_data, reg_wdata;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [7:0] pc;
    logic       halted, illegal;

    instr_sequencer #(.DATA_BUS_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .reg_op(reg_op), .reg_1_sel(reg_1_sel), .reg_2_sel(reg_2_sel),
        .reg_1_data(reg_1_data), .reg_2_data(reg_2_data), .reg_wdata(reg_wdata),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    logic [7:0] rf [4];
    logic [7:0] mem [256];
    assign reg_1_data = rf[reg_1_sel];
    assign reg_2_data = rf[reg_2_sel];

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = reg_1_data + reg_2_data;
            3'd1:    alu_result = reg_1_data - reg_2_data;
            3'd2:    alu_result = reg_1_data & reg_2_data;
            3'd3:    alu_result = reg_1_data | reg_2_data;
            3'd4:    alu_result = reg_1_data ^ reg_2_data;
            default: alu_result = 8'h00;
        endcase
    end
    assign alu_zero = (alu_result == 8'h00);

    int n_tests = 0, n_fail = 0;
    int cyc, waits, wait_cnt, reg_writes, ill_cnt, req_cnt, watch_cnt, halt_cyc;
    bit mem_auto;
    bit wr_pend;
    logic [1:0] wr_sel, last_wsel;
    logic [7:0] wr_data, last_wdata, watch_addr, watch_wd;
    logic       watch_we;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_rf [4];
    logic [7:0] ref_pc;
    int         ref_cyc, ref_ill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe_react();
        if (reg_op === 1'b1) begin
            reg_writes++;
            last_wsel  = reg_1_sel;
            last_wdata = reg_wdata;
            wr_pend    = 1'b1;
            wr_sel     = reg_1_sel;
            wr_data    = reg_wdata;
        end
        if (illegal === 1'b1) ill_cnt++;
        if (mem_req === 1'b1) req_cnt++;
        if (mem_req === 1'b1 && mem_addr === watch_addr) begin
            watch_cnt++;
            watch_we = mem_we;
            watch_wd = mem_wdata;
        end
        if (halted === 1'b1 && halt_cyc == 0) halt_cyc = cyc;
        if (mem_auto) begin
            if (mem_req === 1'b1) begin
                if (wait_cnt < waits) begin
                    wait_cnt++;
                    mem_ack = 1'b0;
                end else begin
                    wait_cnt  = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    endtask

    // register file commits the previous cycle's write on this falling edge
    task automatic cycle();
        @(negedge clock);
        if (wr_pend) begin
            rf[wr_sel] = wr_data;
            wr_pend    = 1'b0;
        end
        #1;
        cyc++;
        observe_react();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        mem_ack = 1'b0;
        cycle();
        reset      = 1'b1;
        wr_pend    = 1'b0;
        #1;
        cyc        = 1;
        wait_cnt   = 0;
        reg_writes = 0;
        ill_cnt    = 0;
        req_cnt    = 0;
        watch_cnt  = 0;
        halt_cyc   = 0;
        observe_react();
    endtask

    task automatic run_to_halt(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && halt_cyc == 0; i++) cycle();
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Instruction-level reference: architectural effects plus cycle cost of each instruction.
    task automatic ref_run(output bit ok);
        logic [7:0] ir, imm, res, a, b;
        logic [3:0] op;
        int         rd, rs;
        bit         z;
        ok = 1'b0; z = 1'b0; ref_pc = 8'h00; ref_cyc = 0; ref_ill = 0; imm = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 4; i++) ref_rf[i] = rf[i];
        for (int s = 0; s < 60; s++) begin
            ir = ref_mem[ref_pc];
            ref_pc = ref_pc + 8'd1;
            ref_cyc += 1 + waits;
            op = ir[7:4]; rd = int'(ir[3:2]); rs = int'(ir[1:0]);
            if (op == 4'hF) begin
                ref_cyc += 1;
                ok = 1'b1;
                break;
            end
            if (op == 4'h1 || op == 4'hA || op == 4'hB) begin
                imm = ref_mem[ref_pc];
                ref_pc = ref_pc + 8'd1;
                ref_cyc += 3 + waits;
            end else begin
                ref_cyc += 2;
            end
            a = ref_rf[rd]; b = ref_rf[rs];
            case (op)
                4'h1: ref_rf[rd] = imm;
                4'h2: ref_rf[rd] = b;
                4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    case (op)
                        4'h3:    res = a + b;
                        4'h4:    res = a - b;
                        4'h5:    res = a & b;
                        4'h6:    res = a | b;
                        default: res = a ^ b;
                    endcase
                    ref_rf[rd] = res;
                    z = (res == 8'h00);
                end
                4'h8: begin
                    ref_rf[rd] = ref_mem[b];
                    ref_cyc += 2 + waits;
                end
                4'h9: begin
                    ref_mem[b] = a;
                    ref_cyc += 1 + waits;
                end
                4'hA: ref_pc = imm;
                4'hB: if (z) ref_pc = imm;
                4'hC, 4'hD, 4'hE: ref_ill++;
                default: ;
            endcase
        end
    endtask

    initial begin
        bit ok;
        int diffs, n;
        logic [3:0] op;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        fill_mem(8'hF0);
        mem_auto = 1'b0; wr_pend = 1'b0; waits = 0; cyc = 0; halt_cyc = 0;
        watch_addr = 8'h00; watch_we = 1'b0; watch_wd = 8'h00;

        // reset behaviour, including an ack presented while reset is held
        cycle();
        reset = 1'b1;
        cycle(); cycle();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_req", 32'(mem_req), 32'd0);
            check("rst_outs", 32'({mem_we, reg_op, illegal, halted}), 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
        end
        reset = 1'b1; mem_ack = 1'b0;
        #1;
        check("rel_req_addr", 32'({mem_req, mem_addr}), 32'h100);
        mem_auto = 1'b1;

        // LDI r0,#5A with zero-wait memory
        fill_mem(8'hF0); mem[0] = 8'h10; mem[1] = 8'h5A;
        do_reset();
        repeat (4) cycle();
        check("ldi_next_fetch", 32'({mem_req, mem_addr}), 32'h102);
        check("ldi_pc", 32'(pc), 32'h02);
        check("ldi_writes", 32'(reg_writes), 32'd1);
        check("ldi_sel", 32'(last_wsel), 32'd0);
        check("ldi_data", 32'(last_wdata), 32'h5A);

        // ADD r1,r2 giving zero, then JZ taken
        fill_mem(8'hF0); mem[0] = 8'h36; mem[1] = 8'hB0; mem[2] = 8'h20;
        rf[1] = 8'h03; rf[2] = 8'hFD;
        do_reset();
        cycle(); cycle();
        check("add_reg_op", 32'(reg_op), 32'd1);
        check("add_alu_op", 32'(alu_op), 32'd0);
        check("add_wdata", 32'(reg_wdata), 32'h00);
        run_to_halt("jz_t", 60);
        check("jz_taken_pc", 32'(pc), 32'h21);
        check("add_r1", 32'(rf[1]), 32'h00);

        // nonzero sum, JZ falls through
        rf[1] = 8'h03; rf[2] = 8'h01;
        do_reset();
        run_to_halt("jz_nt", 60);
        check("jz_fall_pc", 32'(pc), 32'h04);
        check("add_r1_nz", 32'(rf[1]), 32'h04);

        // LD r3,[r0] with two wait states per access
        fill_mem(8'hF0); mem[0] = 8'h8C; mem[8'h40] = 8'h77;
        rf[0] = 8'h40; rf[3] = 8'h00; waits = 2; watch_addr = 8'h40;
        do_reset();
        run_to_halt("ld", 80);
        check("ld_addr_hold", 32'(watch_cnt), 32'd3);
        check("ld_we", 32'(watch_we), 32'd0);
        check("ld_writes", 32'(reg_writes), 32'd1);
        check("ld_sel", 32'(last_wsel), 32'd3);
        check("ld_data", 32'(last_wdata), 32'h77);
        check("ld_halt_cycle", 32'(halt_cyc), 32'd14);

        // ST [r0],r3 with one wait state
        fill_mem(8'hF0); mem[0] = 8'h9C;
        rf[0] = 8'h50; rf[3] = 8'hA5; waits = 1; watch_addr = 8'h50;
        do_reset();
        run_to_halt("st", 60);
        check("st_we", 32'(watch_we), 32'd1);
        check("st_wdata", 32'(watch_wd), 32'hA5);
        check("st_mem", 32'(mem[8'h50]), 32'hA5);
        check("st_writes", 32'(reg_writes), 32'd0);
        check("st_halt_cycle", 32'(halt_cyc), 32'd10);

        // pc wrap: JMP #FF, NOP at FF, next fetch at 00
        fill_mem(8'hF0); mem[0] = 8'hA0; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
        waits = 0; watch_addr = 8'h00;
        do_reset();
        repeat (4) cycle();
        check("wrap_fetch_ff", 32'({mem_req, mem_addr}), 32'h1FF);
        repeat (3) cycle();
        check("wrap_fetch_00", 32'({mem_req, mem_addr}), 32'h100);
        check("wrap_pc", 32'(pc), 32'h00);

        // illegal opcode, then HALT holds until reset
        fill_mem(8'hF0); mem[0] = 8'hD0;
        rf[0] = 8'h11; rf[1] = 8'h22; rf[2] = 8'h33; rf[3] = 8'h44;
        do_reset();
        run_to_halt("ill", 60);
        check("ill_pulses", 32'(ill_cnt), 32'd1);
        check("ill_writes", 32'(reg_writes), 32'd0);
        check("ill_regs", {rf[0], rf[1], rf[2], rf[3]}, 32'h11223344);
        req_cnt = 0;
        repeat (20) cycle();
        check("halt_no_req", 32'(req_cnt), 32'd0);
        check("halt_hold", 32'(halted), 32'd1);
        do_reset();
        check("halt_restart", 32'({halted, mem_req, mem_addr}), 32'h100);

        // random programs against the instruction-level model
        for (int p = 0; p < 30; p++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                for (int i = 0; i < 256; i++)
                    mem[i] = (i >= 8'h40 && i < 8'hC0) ? 8'($urandom) : 8'hF0;
                n = 0;
                for (int k = $urandom_range(1, 12); k > 0; k--) begin
                    op = 4'($urandom_range(0, 14));
                    mem[n] = {op, 4'($urandom)};
                    n++;
                    if (op == 4'h1) begin
                        mem[n] = 8'($urandom); n++;
                    end else if (op == 4'hA || op == 4'hB) begin
                        mem[n] = 8'($urandom_range(0, 63)); n++;
                    end
                end
                for (int i = 0; i < 4; i++) rf[i] = 8'($urandom);
                waits = $urandom_range(0, 2);
                ref_run(ok);
            end
            if (ok) begin
                do_reset();
                for (int i = 0; i < ref_cyc + 20 && halt_cyc == 0; i++) cycle();
                check("rnd_halt_cycle", 32'(halt_cyc), 32'(ref_cyc + 1));
                check("rnd_pc", 32'(pc), 32'(ref_pc));
                check("rnd_regs", {rf[0], rf[1], rf[2], rf[3]},
                      {ref_rf[0], ref_rf[1], ref_rf[2], ref_rf[3]});
                check("rnd_illegal", 32'(ill_cnt), 32'(ref_ill));
                diffs = 0;
                for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
                check("rnd_mem", 32'(diffs), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
